// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit and its ALU:
// FSM states, opcodes, function codes, ALUOp classes and ALU control codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp class and the instruction funct field to the ALU code.
// Unknown funct values fall back to add so the writeback still happens.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t      i_aluop,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_aluop)
      ALUOP_SUB:   o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default:     o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-ALU MIPS datapath through fetch, decode,
// execute, memory and writeback, with memory-ready stalls.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  ALU_control,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [3:0]  state_o
);

  state_t     r_state;
  state_t     w_next;
  aluop_t     w_aluop;
  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_reg_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_aluop     = ALUOP_ADD;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_reg_write = 1'b0;
    iord        = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        iord        = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_branch  = 1'b1;
        pc_src    = 2'b01;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_aluop       (w_aluop),
    .i_funct       (funct),
    .o_alu_control (ALU_control)
  );

  // Side-effecting strobes are gated by reset so nothing writes mid-reset.
  assign mem_req   = w_mem_req   & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign ir_write  = w_ir_write  & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign pc_en     = (w_pc_write | (w_branch & zero)) & ~reset;
  assign state_o   = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: a per-instruction state plan plus a per-state output
// table predict every cycle; one compare process checks the DUT each cycle.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0]  pc_src, alu_src_b;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic [2:0]  ALU_control;
  logic [3:0]  state_o;

  int     n_total = 0;
  int     n_pass  = 0;
  logic   check_en = 1'b0;
  state_t exp_state = S_FETCH;
  state_t plan[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALU_control(ALU_control),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic logic [2:0] funct_code(input logic [5:0] fn);
    if (fn == 6'b100010) return 3'b110;
    if (fn == 6'b100100) return 3'b000;
    if (fn == 6'b100101) return 3'b001;
    if (fn == 6'b101010) return 3'b111;
    return 3'b010;
  endfunction

  // Vector order: mem_req mem_write iord ir_write pc_en pc_src alu_src_a
  // alu_src_b ALU_control reg_dst mem_to_reg reg_write
  function automatic logic [15:0] expect_out(input state_t s, input logic mr,
                                             input logic z, input logic [5:0] fn);
    logic rq, wr, ad, ir, pe, sa, rd, m2r, rw;
    logic [1:0] ps, sb;
    logic [2:0] ac;
    {rq, wr, ad, ir, pe, sa, rd, m2r, rw} = '0;
    ps = 2'b00; sb = 2'b00; ac = 3'b010;
    case (s)
      S_FETCH:   begin rq = 1; sb = 2'b01; ir = mr; pe = mr; end
      S_DECODE:  sb = 2'b11;
      S_MEMADR:  begin sa = 1; sb = 2'b10; end
      S_MEMRD:   begin rq = 1; ad = 1; end
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin rq = 1; wr = 1; ad = 1; end
      S_EXECUTE: begin sa = 1; ac = funct_code(fn); end
      S_ALUWB:   begin rd = 1; rw = 1; end
      S_BRANCH:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; end
      S_ADDIWB:  rw = 1;
      S_JUMP:    begin ps = 2'b10; pe = 1; end
      default:   ;
    endcase
    return {rq, wr, ad, ir, pe, ps, sa, sb, ac, rd, m2r, rw};
  endfunction

  // Cycle-by-cycle state sequence of one instruction, including stall cycles.
  task automatic build_plan(input logic [5:0] op, input int sf, input int sm);
    plan.delete();
    repeat (sf + 1) plan.push_back(S_FETCH);
    plan.push_back(S_DECODE);
    if (op == 6'b100011) begin
      plan.push_back(S_MEMADR);
      repeat (sm + 1) plan.push_back(S_MEMRD);
      plan.push_back(S_MEMWB);
    end else if (op == 6'b101011) begin
      plan.push_back(S_MEMADR);
      repeat (sm + 1) plan.push_back(S_MEMWR);
    end else if (op == 6'b000000) begin
      plan.push_back(S_EXECUTE); plan.push_back(S_ALUWB);
    end else if (op == 6'b000100) plan.push_back(S_BRANCH);
    else if (op == 6'b001000) begin
      plan.push_back(S_ADDIEX); plan.push_back(S_ADDIWB);
    end else if (op == 6'b000010) plan.push_back(S_JUMP);
  endtask

  // Called at posedge+1; zmode < 0 means random zero flag.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int sf, input int sm, input int zmode);
    int fs = sf;
    int ms = sm;
    build_plan(op, sf, sm);
    opcode = op;
    funct  = fn;
    foreach (plan[k]) begin
      exp_state = plan[k];
      if (plan[k] == S_FETCH) begin
        mem_ready = (fs == 0); if (fs > 0) fs--;
      end else if (plan[k] == S_MEMRD || plan[k] == S_MEMWR) begin
        mem_ready = (ms == 0); if (ms > 0) ms--;
      end else mem_ready = 1'($urandom_range(0, 1));
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      check_en = 1'b1;
      @(posedge clk); #1;
    end
    check_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("state", 32'(state_o), 32'(exp_state));
      chk("outputs", 32'({mem_req, mem_write, iord, ir_write, pc_en, pc_src,
                          alu_src_a, alu_src_b, ALU_control, reg_dst,
                          mem_to_reg, reg_write}),
          32'(expect_out(exp_state, mem_ready, zero, funct)));
    end
  end

  logic [5:0] ops [7];
  logic [5:0] fns [6];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};

    // Model pins: cycle counts from the timing table.
    build_plan(6'b100011, 0, 0); chk("len_lw", plan.size(), 5);
    build_plan(6'b100011, 0, 2); chk("len_lw_stall2", plan.size(), 7);
    build_plan(6'b101011, 0, 0); chk("len_sw", plan.size(), 4);
    build_plan(6'b000000, 0, 0); chk("len_rtype", plan.size(), 4);
    build_plan(6'b000100, 0, 0); chk("len_beq", plan.size(), 3);
    build_plan(6'b000010, 1, 0); chk("len_j_fstall", plan.size(), 4);

    mem_ready = 1'b1;
    #12;
    chk("rst_state", 32'(state_o), 32'(S_FETCH));
    chk("rst_strobes", 32'({pc_en, ir_write, reg_write, mem_req, mem_write}), 32'h0);
    chk("rst_alu_src_b", 32'(alu_src_b), 32'h1);
    chk("rst_alu_ctrl", 32'(ALU_control), 32'h2);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b000000, 6'b101010, 0, 0, -1);
    run_instr(6'b000100, 6'b000000, 0, 0, 1);
    run_instr(6'b000100, 6'b000000, 0, 0, 0);
    run_instr(6'b100011, 6'b000000, 0, 2, -1);
    run_instr(6'b111111, 6'b000000, 0, 0, -1);
    run_instr(6'b001000, 6'b000000, 1, 0, -1);
    run_instr(6'b101011, 6'b000000, 0, 1, -1);
    run_instr(6'b000010, 6'b000000, 2, 0, -1);

    for (int i = 0; i < 50; i++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 6)];
      if (op == 6'b111111) op = 6'($urandom_range(0, 63));
      run_instr(op, (i % 3 == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)],
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // Reset asserted while a store waits in MEMWR.
    opcode = 6'b101011; funct = 6'd0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; mem_ready = 1'b0;
    #2;
    chk("mw_state", 32'(state_o), 32'(S_MEMWR));
    chk("mw_write", 32'(mem_write), 32'h1);
    reset = 1'b1;
    #1;
    chk("mw_rst_write", 32'(mem_write), 32'h0);
    chk("mw_rst_req", 32'(mem_req), 32'h0);
    chk("mw_rst_state", 32'(state_o), 32'(S_FETCH));
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    #3;
    chk("after_rst_state", 32'(state_o), 32'(S_FETCH));
    chk("after_rst_fetch", 32'({ir_write, pc_en}), 32'h3);
    @(posedge clk); #3;
    chk("after_rst_decode", 32'(state_o), 32'(S_DECODE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle MIPS control unit that sequences the shared datapath: a single ALU, a unified instruction/data memory, the register file and the PC. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, plus the 3-bit `ALU_control` code consumed by the ALU. It also stalls on a memory ready handshake.

## Interface
- No parameters; all encodings are fixed in `mips_ctrl_pkg`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: `instr[31:26]` from the instruction register.
- `funct` in 6: `instr[5:0]` from the instruction register.
- `zero` in 1: ALU zero flag, valid when a sub is being evaluated.
- `mem_ready` in 1: memory access complete this cycle.
- `mem_req` out 1: memory access requested.
- `mem_write` out 1: request is a write.
- `iord` out 1: memory address select, 0 = PC, 1 = ALU out.
- `ir_write` out 1: load the instruction register.
- `pc_en` out 1: PC load enable, equal to `pc_write | (branch & zero)`.
- `pc_src` out 2: next-PC select, 00 = ALU result, 01 = ALU out, 10 = jump target.
- `alu_src_a` out 1: ALU A select, 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B select, 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALU_control` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `reg_dst` out 1: write register select, 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback source, 0 = ALU out, 1 = memory data.
- `reg_write` out 1: register file write enable.
- `state_o` out 4: current state, for debug and verification.

## Operation
- States:
  - FETCH: `mem_req=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=01`, ALUOp add, `pc_src=00`. `ir_write` and `pc_write` are asserted only in the cycle `mem_ready=1`; hold in FETCH until then.
  - DECODE: `alu_src_a=0`, `alu_src_b=11`, add (branch target into ALU out). Next state by opcode:
    - 100011 lw or 101011 sw → MEMADR
    - 000000 R-type → EXECUTE
    - 000100 beq → BRANCH
    - 001000 addi → ADDIEX
    - 000010 j → JUMP
    - any other opcode → FETCH (executed as a nop)
  - MEMADR: `alu_src_a=1`, `alu_src_b=10`, add. lw → MEMRD, sw → MEMWR.
  - MEMRD: `mem_req=1`, `iord=1`. Hold until `mem_ready`, then → MEMWB.
  - MEMWB: `reg_dst=0`, `mem_to_reg=1`, `reg_write=1`, then → FETCH.
  - MEMWR: `mem_req=1`, `mem_write=1`, `iord=1`. Hold until `mem_ready`, then → FETCH.
  - EXECUTE: `alu_src_a=1`, `alu_src_b=00`, ALUOp funct, then → ALUWB.
  - ALUWB: `reg_dst=1`, `mem_to_reg=0`, `reg_write=1`, then → FETCH.
  - BRANCH: `alu_src_a=1`, `alu_src_b=00`, sub, `branch=1`, `pc_src=01`, then → FETCH.
  - ADDIEX: `alu_src_a=1`, `alu_src_b=10`, add, then → ADDIWB.
  - ADDIWB: `reg_dst=0`, `mem_to_reg=0`, `reg_write=1`, then → FETCH.
  - JUMP: `pc_src=10`, `pc_write=1`, then → FETCH.
- Any output not listed for a state is 0; `ALU_control` defaults to 010.
- ALU decode (ALUOp 00 add, 01 sub, 10 funct). Under funct, `ALU_control` is:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other funct → 010, with `reg_write` still asserted in ALUWB.

## Timing
- All outputs are combinational from the state register only, except `pc_en` and `ir_write` in FETCH, which also depend on `mem_ready`, and `pc_en` in BRANCH, which depends on `zero`.
- While `reset` is high: state = FETCH, and `pc_en`, `ir_write`, `reg_write`, `mem_req`, `mem_write` are forced to 0. Other outputs take their FETCH values (`alu_src_b=01`, `ALU_control=010`, all remaining selects 0).
- Reset asserted mid-instruction returns to FETCH asynchronously. No partial write completes after reset assertion.
- Cycle counts with `mem_ready` tied high:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
- Each cycle `mem_ready` is low in a memory state adds exactly one cycle.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored in every other state.
- `mem_req` stays high and the address select stays stable until the accepting cycle.
- beq: `pc_en` is high in BRANCH only if `zero=1` in that same cycle.

## Structure
- `mips_ctrl_pkg` holds:
  - `state_t` enum (4-bit)
  - opcode and funct localparams
  - `aluop_t`
  - `ALU_control` encodings, shared with the ALU
- Sub-module `alu_decoder`: combinational map from (ALUOp, funct) to `ALU_control`.
- The FSM, its next-state logic and its output decode live in `multicycle_controller`.

## Test plan
- **Reset and fetch:** reset high, then released with `mem_ready=1` → `state_o` = FETCH, and `pc_en`/`ir_write` pulse in the first cycle after release; next state DECODE.
- **R-type slt:** opcode 000000, funct 101010 → EXECUTE drives `ALU_control=111`; ALUWB drives `reg_write=1`, `reg_dst=1`; 4 cycles total.
- **beq both ways:** opcode 000100 with `zero=1` in BRANCH → `pc_en=1`, `pc_src=01`. Repeat with `zero=0` → `pc_en=0`; 3 cycles each.
- **lw with stalls:** opcode 100011, `mem_ready` low for 2 cycles in MEMRD → FSM holds in MEMRD with `iord=1`; 7 cycles total; MEMWB drives `mem_to_reg=1`.
- **Illegal opcode:** opcode 111111 → FETCH follows DECODE with no `reg_write`, `mem_write` or `pc_en`.
- **Reset mid-instruction:** reset asserted during MEMWR → same cycle `mem_write=0`; state FETCH after release.
